// File: rtl/priority_encoder_4to2.sv
// ---------------------------------------------------------------------------
// priority_encoder_4to2
//
// Registered priority encoder. Reports the index of the highest-numbered set
// bit of the request vector, a valid flag and a one-hot decode of the winner.
// All outputs are registered and change only on the rising edge of clk.
//
// Parameters
//   WIDTH  : number of request inputs (2..64), default 4
//   IDX_W  : index width, derived as $clog2(WIDTH)
//
// Ports
//   clk    : in  : sole clock, rising-edge
//   rst_n  : in  : synchronous active-low reset, overrides en
//   en     : in  : 1 = capture new encode result, 0 = hold outputs
//   in     : in  : request vector, bit WIDTH-1 has highest priority
//   out    : out : registered index of highest set bit (0 when none set)
//   valid  : out : registered flag, 1 when any request bit was set
//   onehot : out : registered one-hot of the winning bit, 0 when not valid
// ---------------------------------------------------------------------------
module priority_encoder_4to2 #(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [WIDTH-1:0]           in,
    output logic [$clog2(WIDTH)-1:0]   out,
    output logic                       valid,
    output logic [WIDTH-1:0]           onehot
);

    localparam int IDX_W = $clog2(WIDTH);

    logic [IDX_W-1:0] w_idx;
    logic             w_any;
    logic [WIDTH-1:0] w_oh;

    logic [IDX_W-1:0] r_out;
    logic             r_valid;
    logic [WIDTH-1:0] r_onehot;

    // Ascending scan: later (higher) set bits overwrite earlier ones, so the
    // highest set bit wins. All-zero input leaves idx at 0.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in[i]) begin
                w_idx = IDX_W'(i);
            end
        end
        w_any = |in;
        w_oh  = w_any ? (WIDTH'(1) << w_idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out    <= '0;
            r_valid  <= 1'b0;
            r_onehot <= '0;
        end else if (en) begin
            r_out    <= w_idx;
            r_valid  <= w_any;
            r_onehot <= w_oh;
        end
    end

    assign out    = r_out;
    assign valid  = r_valid;
    assign onehot = r_onehot;

endmodule

// File: tb/tb_priority_encoder_4to2.sv
module tb_priority_encoder_4to2;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] in4;
    logic [1:0] out4;
    logic       valid4;
    logic [3:0] oh4;
    logic [7:0] in8;
    logic [2:0] out8;
    logic       valid8;
    logic [7:0] oh8;

    int n_tests = 0;
    int n_fail  = 0;

    priority_encoder_4to2 #(.WIDTH(4)) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .in     (in4),
        .out    (out4),
        .valid  (valid4),
        .onehot (oh4)
    );

    priority_encoder_4to2 #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .in     (in8),
        .out    (out8),
        .valid  (valid8),
        .onehot (oh8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int unsigned out4;
        int unsigned v4;
        int unsigned oh4;
        int unsigned out8;
        int unsigned v8;
        int unsigned oh8;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: what the registered outputs should hold.
    int unsigned m_out4, m_v4, m_oh4, m_out8, m_v8, m_oh8;

    // Highest set bit found arithmetically: floor(log2(v)) = clog2(v+1)-1.
    task automatic encode(input int unsigned v, output int unsigned idx,
                          output int unsigned any, output int unsigned oh);
        if (v == 0) begin
            idx = 0; any = 0; oh = 0;
        end else begin
            idx = $clog2(v + 1) - 1;
            any = 1;
            oh  = 1 << idx;
        end
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus and push the expected post-edge state.
    task automatic step(input bit r, input bit e, input int unsigned v4, input int unsigned v8);
        exp_t x;
        int unsigned i, a, o;
        @(negedge clk);
        rst_n = r;
        en    = e;
        in4   = v4[3:0];
        in8   = v8[7:0];
        if (!r) begin
            m_out4 = 0; m_v4 = 0; m_oh4 = 0;
            m_out8 = 0; m_v8 = 0; m_oh8 = 0;
        end else if (e) begin
            encode(v4 & 32'hF, i, a, o);
            m_out4 = i; m_v4 = a; m_oh4 = o;
            encode(v8 & 32'hFF, i, a, o);
            m_out8 = i; m_v8 = a; m_oh8 = o;
        end
        x.out4 = m_out4; x.v4 = m_v4; x.oh4 = m_oh4;
        x.out8 = m_out8; x.v8 = m_v8; x.oh8 = m_oh8;
        exp_q.push_back(x);
    endtask

    // Monitor: outputs are presented every cycle, so pop one entry per edge.
    always begin
        exp_t x;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("out4",    32'(out4),   x.out4);
            chk("valid4",  32'(valid4), x.v4);
            chk("onehot4", 32'(oh4),    x.oh4);
            chk("out8",    32'(out8),   x.out8);
            chk("valid8",  32'(valid8), x.v8);
            chk("onehot8", 32'(oh8),    x.oh8);
            chk("inv_valid_or4", 32'(valid4), 32'(|oh4));
            chk("inv_valid_or8", 32'(valid8), 32'(|oh8));
            if (valid4) chk("inv_oh_pos4", 32'(oh4), 32'(4'b0001 << out4));
            else        chk("inv_idle_out4", 32'(out4), 0);
            if (valid8) chk("inv_oh_pos8", 32'(oh8), 32'(8'b00000001 << out8));
            else        chk("inv_idle_out8", 32'(out8), 0);
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        in4   = '0;
        in8   = '0;

        // Reset with requests pending and en high, then release.
        step(0, 1, 4'hF, 8'hFF);
        step(0, 1, 4'hF, 8'hFF);
        step(1, 1, 4'hF, 8'hFF);

        // Single-hot sweep.
        step(1, 1, 4'h0, 8'h00);
        step(1, 1, 4'h1, 8'h01);
        step(1, 1, 4'h2, 8'h02);
        step(1, 1, 4'h4, 8'h40);
        step(1, 1, 4'h8, 8'h80);

        // Multi-hot priority.
        step(1, 1, 4'h6, 8'h36);
        step(1, 1, 4'hC, 8'hC3);
        step(1, 1, 4'h3, 8'h0F);
        step(1, 1, 4'hF, 8'hFF);

        // Enable hold.
        step(1, 1, 4'h4, 8'h10);
        step(1, 0, 4'h8, 8'h80);
        step(1, 0, 4'h0, 8'h00);
        step(1, 0, 4'h0, 8'h00);
        step(1, 1, 4'h0, 8'h00);

        // Reset mid-stream.
        step(1, 1, 4'h8, 8'h80);
        step(0, 1, 4'h8, 8'h80);
        step(1, 1, 4'h8, 8'h80);

        // Exhaustive WIDTH=4, random WIDTH=8.
        for (int v = 0; v < 16; v++) begin
            step(1, 1, v, $urandom_range(0, 255));
        end

        // Random with en/rst_n toggling.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 15), $urandom_range(0, 255));
        end

        @(posedge clk);
        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
